// File: rtl/control_sequencer.sv
`default_nettype none
// control_sequencer: FETCH/DECODE/EXEC/MEM instruction sequencer with registered control word.
// Optional halt opcode (1111 -> HALT state) is enabled by defining CTRL_HALT_EN.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [2:0]  DataReg_A,
  output logic [2:0]  AdderssReg_A,
  output logic [2:0]  AddressReg_B,
  output logic [3:0]  FunctionSelect,
  output logic        MemoryBus,
  output logic        MemoryData,
  output logic        ReadWrite,
  output logic        MemoryWrite,
  output logic        ProgramReg,
  output logic        Jump,
  output logic        Branch,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3
`ifdef CTRL_HALT_EN
    , S_HALT = 3'd4
`endif
  } state_t;

  localparam logic [3:0] c_OP_NOP = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_ADI = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0011;
  localparam logic [3:0] c_OP_MOV = 4'b0100;
  localparam logic [3:0] c_OP_LD  = 4'b0101;
  localparam logic [3:0] c_OP_ST  = 4'b0110;
  localparam logic [3:0] c_OP_BRZ = 4'b0111;
  localparam logic [3:0] c_OP_JMP = 4'b1000;
`ifdef CTRL_HALT_EN
  localparam logic [3:0] c_OP_HLT = 4'b1111;
`endif

  state_t      r_state, w_next;
  logic [15:0] r_instr;
  logic        w_latch;
  logic [3:0]  w_op;

  logic        r_instr_req, r_mem_req, r_mb, r_rw, r_pr, r_jmp, r_brz, r_ill, r_ld, r_st;
  logic [2:0]  r_dr, r_sa, r_sb;
  logic [3:0]  r_fs;
  logic        w_instr_req, w_mem_req, w_mb, w_rw, w_pr, w_jmp, w_brz, w_ill, w_ld, w_st;
  logic [2:0]  w_dr, w_sa, w_sb;
  logic [3:0]  w_fs;
`ifdef CTRL_HALT_EN
  logic        r_halted, w_halted;
`endif

  assign w_op = r_instr[15:12];

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_instr_req && instr_valid) begin
          w_next  = S_DECODE;
          w_latch = 1'b1;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == c_OP_LD || w_op == c_OP_ST)
          w_next = S_MEM;
`ifdef CTRL_HALT_EN
        else if (w_op == c_OP_HLT)
          w_next = S_HALT;
`endif
        else
          w_next = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)
          w_next = S_FETCH;
      end
`ifdef CTRL_HALT_EN
      S_HALT: w_next = S_HALT;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in that state's cycle.
  always_comb begin
    w_instr_req = 1'b0;
    w_mem_req   = 1'b0;
    w_dr        = 3'd0;
    w_sa        = 3'd0;
    w_sb        = 3'd0;
    w_fs        = 4'd0;
    w_mb        = 1'b0;
    w_rw        = 1'b0;
    w_pr        = 1'b0;
    w_jmp       = 1'b0;
    w_brz       = 1'b0;
    w_ill       = 1'b0;
    w_ld        = 1'b0;
    w_st        = 1'b0;
`ifdef CTRL_HALT_EN
    w_halted    = 1'b0;
`endif
    case (w_next)
      S_FETCH: w_instr_req = 1'b1;
      S_EXEC: begin
        w_dr = r_instr[11:9];
        w_sa = r_instr[8:6];
        w_sb = r_instr[5:3];
        w_pr = 1'b1;
        case (w_op)
          c_OP_NOP: ;
          c_OP_ADD: begin w_fs = 4'b0010; w_rw = 1'b1; end
          c_OP_ADI: begin w_fs = 4'b0010; w_mb = 1'b1; w_rw = 1'b1; w_sb = r_instr[2:0]; end
          c_OP_SUB: begin w_fs = 4'b0101; w_rw = 1'b1; end
          c_OP_MOV: w_rw = 1'b1;
          c_OP_LD, c_OP_ST: w_pr = 1'b0;
          c_OP_BRZ: w_brz = 1'b1;
          c_OP_JMP: w_jmp = 1'b1;
`ifdef CTRL_HALT_EN
          c_OP_HLT: ;
`endif
          default:  w_ill = 1'b1;
        endcase
      end
      S_MEM: begin
        w_dr      = r_instr[11:9];
        w_sa      = r_instr[8:6];
        w_sb      = r_instr[5:3];
        w_mem_req = 1'b1;
        w_ld      = (w_op == c_OP_LD);
        w_st      = (w_op == c_OP_ST);
      end
`ifdef CTRL_HALT_EN
      S_HALT: w_halted = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_instr     <= 16'd0;
      r_instr_req <= 1'b0;
      r_mem_req   <= 1'b0;
      r_dr        <= 3'd0;
      r_sa        <= 3'd0;
      r_sb        <= 3'd0;
      r_fs        <= 4'd0;
      r_mb        <= 1'b0;
      r_rw        <= 1'b0;
      r_pr        <= 1'b0;
      r_jmp       <= 1'b0;
      r_brz       <= 1'b0;
      r_ill       <= 1'b0;
      r_ld        <= 1'b0;
      r_st        <= 1'b0;
`ifdef CTRL_HALT_EN
      r_halted    <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      if (w_latch)
        r_instr   <= instr;
      r_instr_req <= w_instr_req;
      r_mem_req   <= w_mem_req;
      r_dr        <= w_dr;
      r_sa        <= w_sa;
      r_sb        <= w_sb;
      r_fs        <= w_fs;
      r_mb        <= w_mb;
      r_rw        <= w_rw;
      r_pr        <= w_pr;
      r_jmp       <= w_jmp;
      r_brz       <= w_brz;
      r_ill       <= w_ill;
      r_ld        <= w_ld;
      r_st        <= w_st;
`ifdef CTRL_HALT_EN
      r_halted    <= w_halted;
`endif
    end
  end

  // Same-cycle qualifiers: zero in EXEC and mem_ready in MEM gate the registered enables.
  assign instr_req      = r_instr_req;
  assign mem_req        = r_mem_req;
  assign DataReg_A      = r_dr;
  assign AdderssReg_A   = r_sa;
  assign AddressReg_B   = r_sb;
  assign FunctionSelect = r_fs;
  assign MemoryBus      = r_mb;
  assign MemoryData     = r_ld & mem_ready;
  assign ReadWrite      = r_rw | (r_ld & mem_ready);
  assign MemoryWrite    = r_st & mem_ready;
  assign ProgramReg     = r_pr | (r_mem_req & mem_ready);
  assign Jump           = r_jmp;
  assign Branch         = r_brz & zero;
  assign illegal        = r_ill;
`ifdef CTRL_HALT_EN
  assign halted         = r_halted;
`else
  assign halted         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer: table-driven directed vectors plus hand sequences for memory, reset and halt.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, instr_valid, mem_ready, zero;
  logic [15:0] instr;
  logic        instr_req, mem_req, MemoryBus, MemoryData, ReadWrite, MemoryWrite;
  logic        ProgramReg, Jump, Branch, illegal, halted;
  logic [2:0]  DataReg_A, AdderssReg_A, AddressReg_B;
  logic [3:0]  FunctionSelect;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_valid(instr_valid), .instr(instr),
    .mem_req(mem_req), .mem_ready(mem_ready), .zero(zero),
    .DataReg_A(DataReg_A), .AdderssReg_A(AdderssReg_A), .AddressReg_B(AddressReg_B),
    .FunctionSelect(FunctionSelect), .MemoryBus(MemoryBus), .MemoryData(MemoryData),
    .ReadWrite(ReadWrite), .MemoryWrite(MemoryWrite), .ProgramReg(ProgramReg),
    .Jump(Jump), .Branch(Branch), .illegal(illegal), .halted(halted)
  );

  localparam logic [10:0] c_MB   = 11'h400;
  localparam logic [10:0] c_MD   = 11'h200;
  localparam logic [10:0] c_RW   = 11'h100;
  localparam logic [10:0] c_MW   = 11'h080;
  localparam logic [10:0] c_PR   = 11'h040;
  localparam logic [10:0] c_J    = 11'h020;
  localparam logic [10:0] c_B    = 11'h010;
  localparam logic [10:0] c_ILL  = 11'h008;
  localparam logic [10:0] c_HLT  = 11'h004;
  localparam logic [10:0] c_IREQ = 11'h002;
  localparam logic [10:0] c_MREQ = 11'h001;

  logic [23:0] w_obs;
  assign w_obs = {DataReg_A, AdderssReg_A, AddressReg_B, FunctionSelect,
                  MemoryBus, MemoryData, ReadWrite, MemoryWrite, ProgramReg,
                  Jump, Branch, illegal, halted, instr_req, mem_req};

  typedef struct {
    logic [15:0] instr;
    logic        zero;
    logic [2:0]  dr, sa, sb;
    logic [3:0]  fs;
    logic [10:0] st;
  } vec_t;

  vec_t vecs[12];
  int   n_vec;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [23:0] mk(input logic [2:0] dr, input logic [2:0] sa,
                                     input logic [2:0] sb, input logic [3:0] fs,
                                     input logic [10:0] st);
    return {dr, sa, sb, fs, st};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an instruction and wait (bounded) for the FETCH cycle that accepts it.
  task automatic do_fetch(input logic [15:0] ins, input logic z);
    int n;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    zero = z;
    while (!instr_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!instr_req) begin
      n_checks++;
      n_errors++;
      $display("FAIL fetch_timeout: instr_req got 0 expected 1 for instr %h", ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'h1299, 1'b0, 3'd1, 3'd2, 3'd3, 4'b0010, c_RW | c_PR};
    vecs[1]  = '{16'h2A57, 1'b0, 3'd5, 3'd1, 3'd7, 4'b0010, c_MB | c_RW | c_PR};
    vecs[2]  = '{16'h3E3F, 1'b0, 3'd7, 3'd0, 3'd7, 4'b0101, c_RW | c_PR};
    vecs[3]  = '{16'h4C40, 1'b0, 3'd6, 3'd1, 3'd0, 4'b0000, c_RW | c_PR};
    vecs[4]  = '{16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, c_PR};
    vecs[5]  = '{16'h7000, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, c_PR};
    vecs[6]  = '{16'h7000, 1'b1, 3'd0, 3'd0, 3'd0, 4'b0000, c_PR | c_B};
    vecs[7]  = '{16'h8123, 1'b0, 3'd0, 3'd4, 3'd4, 4'b0000, c_PR | c_J};
    vecs[8]  = '{16'h9000, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, c_PR | c_ILL};
    vecs[9]  = '{16'hE1FF, 1'b0, 3'd0, 3'd7, 3'd7, 4'b0000, c_PR | c_ILL};
    vecs[10] = '{16'h1E07, 1'b1, 3'd7, 3'd0, 3'd0, 4'b0010, c_RW | c_PR};
    vecs[11] = '{16'hF000, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, c_PR | c_ILL};
`ifdef CTRL_HALT_EN
    n_vec = 11;
`else
    n_vec = 12;
`endif

    reset = 1'b1; instr_valid = 1'b1; instr = 16'h1299; mem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_state", w_obs, '0);
    reset = 1'b0;
    @(negedge clk); #1 check("first_ireq", w_obs, mk(0, 0, 0, 0, c_IREQ));

    // Back-to-back single-cycle ops with instr_valid held high: 3-cycle cadence.
    for (int i = 0; i < n_vec; i++) begin
      do_fetch(vecs[i].instr, vecs[i].zero);
      @(negedge clk); #1 check($sformatf("decode[%0d]", i), w_obs, '0);
      @(negedge clk); #1 check($sformatf("exec[%0d]", i), w_obs,
                               mk(vecs[i].dr, vecs[i].sa, vecs[i].sb, vecs[i].fs, vecs[i].st));
      @(negedge clk); #1 check($sformatf("refetch[%0d]", i), w_obs, mk(0, 0, 0, 0, c_IREQ));
    end

    // LD with three wait cycles; instr change outside FETCH must be ignored.
    do_fetch(16'h5498, 1'b0);
    @(negedge clk); #1 check("ld_decode", w_obs, '0);
    instr = 16'h3FFF;
    @(negedge clk); #1 check("ld_exec", w_obs, mk(2, 2, 3, 0, 11'h000));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b0;
      #1 check($sformatf("ld_wait[%0d]", i), w_obs, mk(2, 2, 3, 0, c_MREQ));
    end
    @(negedge clk); mem_ready = 1'b1;
    #1 check("ld_done", w_obs, mk(2, 2, 3, 0, c_MREQ | c_RW | c_MD | c_PR));
    @(negedge clk); mem_ready = 1'b0;
    #1 check("ld_refetch", w_obs, mk(0, 0, 0, 0, c_IREQ));

    // ST completing in its first MEM cycle.
    do_fetch(16'h6ABC, 1'b0);
    @(negedge clk); #1 check("st_decode", w_obs, '0);
    @(negedge clk); #1 check("st_exec", w_obs, mk(5, 2, 7, 0, 11'h000));
    @(negedge clk); mem_ready = 1'b1;
    #1 check("st_done", w_obs, mk(5, 2, 7, 0, c_MREQ | c_MW | c_PR));
    @(negedge clk); mem_ready = 1'b0;
    #1 check("st_refetch", w_obs, mk(0, 0, 0, 0, c_IREQ));

    // Reset in the middle of a stalled memory access.
    do_fetch(16'h5498, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1 check("mid_mem_wait", w_obs, mk(2, 2, 3, 0, c_MREQ));
    reset = 1'b1;
    @(negedge clk); #1 check("mid_mem_reset", w_obs, '0);
    reset = 1'b0;
    @(negedge clk); #1 check("post_reset_ireq", w_obs, mk(0, 0, 0, 0, c_IREQ));
    do_fetch(16'h1299, 1'b0);
    @(negedge clk); #1 check("post_reset_decode", w_obs, '0);
    @(negedge clk); #1 check("post_reset_exec", w_obs, mk(1, 2, 3, 4'b0010, c_RW | c_PR));
    @(negedge clk); #1 check("post_reset_refetch", w_obs, mk(0, 0, 0, 0, c_IREQ));

`ifdef CTRL_HALT_EN
    do_fetch(16'hF000, 1'b0);
    @(negedge clk); #1 check("halt_decode", w_obs, '0);
    @(negedge clk); #1 check("halt_exec", w_obs, mk(0, 0, 0, 0, c_PR));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 check($sformatf("halted[%0d]", i), w_obs, mk(0, 0, 0, 0, c_HLT));
    end
    reset = 1'b1;
    @(negedge clk); #1 check("halt_reset", w_obs, '0);
    reset = 1'b0;
    @(negedge clk); #1 check("halt_release_ireq", w_obs, mk(0, 0, 0, 0, c_IREQ));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
